// File: rtl/bit_serializer_pkg.sv
// rtl/bit_serializer_pkg.sv - shared state encodings and frame-length helper for bit_serializer
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  function automatic int frame_len(input int width, input bit parity);
    return parity ? width + 1 : width;
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// rtl/ser_bit_counter.sv - bit-position up-counter with clear, enable and terminal-count flag
module ser_bit_counter #(
  parameter int               CNT_W = 4,
  parameter logic [CNT_W-1:0] TERM  = '1
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  // Clear wins over enable so a back-to-back load restarts at bit 0.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CNT_W'(1);
  end

  assign tc = (cnt == TERM);

endmodule

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - LSB-first word-to-bit serializer with valid/ready input and en/d/last output
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_stall,
  output logic             o_en,
  output logic             o_d,
  output logic             o_last,
  output logic             o_busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SERIALIZER_PARITY_EN
  localparam bit               PAR_EN    = 1'b1;
  localparam logic [CNT_W-1:0] SHIFT_END = CNT_W'(WIDTH - 1);
`else
  localparam bit               PAR_EN    = 1'b0;
`endif
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(frame_len(WIDTH, PAR_EN) - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q;
  logic [CNT_W-1:0]   cnt;
  logic               tc;
  logic               busy;
  logic               final_bit;
  logic               accept;
  logic               shift_in;

  assign busy      = (state_q != ST_IDLE);
  assign final_bit = busy && tc;
  assign o_en      = busy && !i_stall;
  // Opening the ready window on the final bit lets the next word follow with no gap.
  assign o_ready   = !i_rst && (!busy || (final_bit && !i_stall));
  assign accept    = i_valid && o_ready;
  assign o_last    = o_en && final_bit;
  assign o_busy    = busy;
  assign o_d       = data_q[0];

  ser_bit_counter #(
    .CNT_W (CNT_W),
    .TERM  (LAST_CNT)
  ) u_cnt (
    .clk   (clk),
    .i_rst (i_rst),
    .clr   (accept || o_last),
    .en    (o_en),
    .cnt   (cnt),
    .tc    (tc)
  );

`ifdef SERIALIZER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)       par_q <= 1'b0;
    else if (accept) par_q <= ^i_data;
  end

  // Parity enters at the MSB so it reaches data_q[0] exactly after the last data bit.
  assign shift_in = par_q;
`else
  assign shift_in = 1'b0;
`endif

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst)       data_q <= '0;
    else if (accept) data_q <= i_data;
    else if (o_en)   data_q <= {shift_in, data_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
`ifdef SERIALIZER_PARITY_EN
        if (o_en && (cnt == SHIFT_END)) state_d = ST_PARITY;
`else
        if (o_last) state_d = accept ? ST_SHIFT : ST_IDLE;
`endif
      end
      ST_PARITY: begin
        if (o_last) state_d = accept ? ST_SHIFT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - table-driven self-checking bench for bit_serializer (WIDTH=8)
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_data;
  logic       i_stall;
  logic       o_en;
  logic       o_d;
  logic       o_last;
  logic       o_busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       stall;
    logic       en;
    logic       d;
    logic       last;
    logic       ready;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  bit_serializer #(.WIDTH(8)) dut (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .i_stall (i_stall),
    .o_en    (o_en),
    .o_d     (o_d),
    .o_last  (o_last),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic v, input logic [7:0] dt, input logic s,
                              input logic en, input logic d, input logic last,
                              input logic rdy, input logic bsy);
    vec_t r;
    r.valid = v; r.data = dt; r.stall = s;
    r.en = en; r.d = d; r.last = last; r.ready = rdy; r.busy = bsy;
    return r;
  endfunction

  // Eight unstalled data-bit cycles of word w; nv/nd are presented on the last one.
  function automatic void push_frame(input logic [7:0] w, input logic nv, input logic [7:0] nd);
    for (int k = 0; k < 8; k++) begin
`ifdef SERIALIZER_PARITY_EN
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, w[k], 1'b0, 1'b0, 1'b1));
`else
      tbl.push_back(mk((k == 7) ? nv : 1'b0, nd, 1'b0, 1'b1, w[k], k == 7, k == 7, 1'b1));
`endif
    end
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    i_valid = v.valid;
    i_data  = v.data;
    i_stall = v.stall;
    #1;
    chk({tag, ".en"},    o_en,    v.en);
    chk({tag, ".d"},     o_d,     v.d);
    chk({tag, ".last"},  o_last,  v.last);
    chk({tag, ".ready"}, o_ready, v.ready);
    chk({tag, ".busy"},  o_busy,  v.busy);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b1; i_data = 8'hFF; i_stall = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.ready", o_ready, 1'b0);
    chk("rst.en",    o_en,    1'b0);
    chk("rst.d",     o_d,     1'b0);
    chk("rst.last",  o_last,  1'b0);
    chk("rst.busy",  o_busy,  1'b0);
    i_valid = 1'b0;
    i_rst   = 1'b0;
    #1;
    chk("rst_rel.ready", o_ready, 1'b1);

`ifdef SERIALIZER_PARITY_EN
    // 0xA5 (parity 0) followed back-to-back by 0x07 (parity 1)
    tbl.push_back(mk(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    push_frame(8'hA5, 1'b0, 8'h00);
    tbl.push_back(mk(1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    push_frame(8'h07, 1'b0, 8'h00);
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    foreach (tbl[i]) run_vec($sformatf("par[%0d]", i), tbl[i]);
`else
    // single word 0xA5
    tbl.push_back(mk(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    push_frame(8'hA5, 1'b0, 8'h00);
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    // back-to-back 0xA5 then 0x3C
    tbl.push_back(mk(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    push_frame(8'hA5, 1'b1, 8'h3C);
    push_frame(8'h3C, 1'b0, 8'h00);
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    // garbage offered mid-frame must be refused
    tbl.push_back(mk(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int k = 0; k < 8; k++) begin
      logic [7:0] w;
      w = 8'hC3;
      tbl.push_back(mk(k >= 1 && k <= 3, 8'hFF, 1'b0, 1'b1, w[k], k == 7, k == 7, 1'b1));
    end
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    // stall after bit 2, then a stall on the final bit with valid held
    tbl.push_back(mk(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    for (int k = 4; k < 7; k++)
      tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    foreach (tbl[i]) run_vec($sformatf("vec[%0d]", i), tbl[i]);

    // asynchronous reset in the middle of 0xFF
    run_vec("rstmf.acc", mk(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int k = 0; k < 4; k++)
      run_vec($sformatf("rstmf.b%0d", k), mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    i_valid = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    chk("rstmf.en",    o_en,    1'b0);
    chk("rstmf.d",     o_d,     1'b0);
    chk("rstmf.last",  o_last,  1'b0);
    chk("rstmf.busy",  o_busy,  1'b0);
    chk("rstmf.ready", o_ready, 1'b0);
    @(negedge clk);
    i_valid = 1'b1;
    #1;
    chk("rstmf.hold_ready", o_ready, 1'b0);
    chk("rstmf.hold_busy",  o_busy,  1'b0);
    i_valid = 1'b0;
    i_rst   = 1'b0;
    #1;
    chk("rstmf.rel_ready", o_ready, 1'b1);
    chk("rstmf.rel_busy",  o_busy,  1'b0);
    run_vec("post.acc", mk(1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    for (int k = 0; k < 8; k++)
      run_vec($sformatf("post.b%0d", k), mk(1'b0, 8'h00, 1'b0, 1'b1, k == 0, k == 7, k == 7, 1'b1));
    run_vec("post.idle", mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
